// File: rtl/servo_pwm_gen_pkg.sv
// Shared definitions for the servo PWM generator: command width, the "off"
// command value and a width helper for elaboration-time counter sizing.
package servo_pwm_gen_pkg;

    localparam int SERVO_CMD_W = 8;
    localparam logic [SERVO_CMD_W-1:0] SERVO_OFF = '0;
    localparam int SERVO_CMD_MAX = (1 << SERVO_CMD_W) - 1;
    localparam int US_PER_SEC = 1_000_000;

    // Guards against zero-width vectors when a count range collapses to one value.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: frame-synchronous command shadow, pulse-length computation
// and the registered compare that drives the pin.
module servo_pwm_channel
    import servo_pwm_gen_pkg::*;
#(
    parameter int CNT_W        = 15,
    parameter int MIN_PULSE_US = 1000,
    parameter int STEP_US      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load,
    input  logic [SERVO_CMD_W-1:0] cmd,
    input  logic [CNT_W-1:0]       us_cnt,
    output logic                   pwm
);

    localparam int LEN_W = CNT_W + 1;
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PULSE_US);
    localparam logic [LEN_W-1:0] STEP_LEN = LEN_W'(STEP_US);

    logic [SERVO_CMD_W-1:0] shadow;
    logic [LEN_W-1:0]       len;
    logic                   pwm_next;

    // The command is only taken at the frame boundary so a pulse never changes width mid-flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= SERVO_OFF;
        end else if (load) begin
            shadow <= cmd;
        end
    end

    always_comb begin
        len      = MIN_LEN + LEN_W'(shadow) * STEP_LEN;
        pwm_next = en && (shadow != SERVO_OFF) && ({1'b0, us_cnt} < len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= pwm_next;
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Dual hobby-servo PWM generator: a microsecond timebase shared by two
// independent channels, plus a one-clock strobe at the start of each frame.
module servo_pwm_gen
    import servo_pwm_gen_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int STEP_US      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [SERVO_CMD_W-1:0] servo_l,
    input  logic [SERVO_CMD_W-1:0] servo_r,
    output logic                   pwm_l,
    output logic                   pwm_r,
    output logic                   frame_start
);

    localparam int DIV   = CLK_FREQ_HZ / US_PER_SEC;
    localparam int PS_W  = width_of(DIV);
    localparam int CNT_W = width_of(PERIOD_US);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_US - 1);

    if ((CLK_FREQ_HZ % US_PER_SEC) != 0 || DIV < 1) begin : g_bad_clk
        $error("servo_pwm_gen: CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
    end

    if (MIN_PULSE_US + SERVO_CMD_MAX * STEP_US >= PERIOD_US) begin : g_bad_pulse
        $error("servo_pwm_gen: longest pulse does not fit inside PERIOD_US");
    end

    logic [PS_W-1:0]  prescaler;
    logic [CNT_W-1:0] us_cnt;
    logic             tick;
    logic             wrap;

    always_comb begin
        tick = (prescaler == PS_LAST);
        wrap = tick && (us_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt <= '0;
        end else if (wrap) begin
            us_cnt <= '0;
        end else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
        end
    end

    servo_pwm_channel #(
        .CNT_W        (CNT_W),
        .MIN_PULSE_US (MIN_PULSE_US),
        .STEP_US      (STEP_US)
    ) u_chan_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (wrap),
        .cmd    (servo_l),
        .us_cnt (us_cnt),
        .pwm    (pwm_l)
    );

    servo_pwm_channel #(
        .CNT_W        (CNT_W),
        .MIN_PULSE_US (MIN_PULSE_US),
        .STEP_US      (STEP_US)
    ) u_chan_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (wrap),
        .cmd    (servo_r),
        .us_cnt (us_cnt),
        .pwm    (pwm_r)
    );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen at a scaled-down timebase: 2 clocks per us,
// 300 us frames (600 clocks), pulse = 10 us + cmd * 1 us.
module tb_servo_pwm_gen;

    localparam int CLK_HZ = 2_000_000;
    localparam int PER_US = 300;
    localparam int MIN_US = 10;
    localparam int STP_US = 1;
    localparam int FRAME  = 600;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] servo_l;
    logic [7:0] servo_r;
    logic       pwm_l;
    logic       pwm_r;
    logic       frame_start;

    int n_cmp = 0;
    int n_err = 0;

    logic [FRAME-1:0] pw_l;
    logic [FRAME-1:0] pw_r;
    logic [FRAME-1:0] fs_v;
    logic             fs_next;
    int               gap;
    int               l_hi;
    int               r_hi;

    servo_pwm_gen #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .PERIOD_US    (PER_US),
        .MIN_PULSE_US (MIN_US),
        .STEP_US      (STP_US)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .servo_l     (servo_l),
        .servo_r     (servo_r),
        .pwm_l       (pwm_l),
        .pwm_r       (pwm_r),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int first_one(input logic [FRAME-1:0] v);
        for (int i = 0; i < FRAME; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last_one(input logic [FRAME-1:0] v);
        for (int i = FRAME - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    // Counts negedges until frame_start is seen, bounded to two frames.
    task automatic wait_fs(output int g, output int lh, output int rh);
        g  = 0;
        lh = 0;
        rh = 0;
        do begin
            @(negedge clk);
            g++;
            if (pwm_l) lh++;
            if (pwm_r) rh++;
        end while (!frame_start && g < 2 * FRAME);
    endtask

    // Entered on the negedge where frame_start is high (index 0); records one
    // frame of samples and leaves on the next frame's index 0.
    task automatic run_frame(input int l_idx, input logic [7:0] l_val,
                             input int r_idx, input logic [7:0] r_val,
                             input int en_off, input int en_on);
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            pw_l[i] = pwm_l;
            pw_r[i] = pwm_r;
            fs_v[i] = frame_start;
            if (i == l_idx)  servo_l = l_val;
            if (i == r_idx)  servo_r = r_val;
            if (i == en_off) en = 1'b0;
            if (i == en_on)  en = 1'b1;
        end
        @(negedge clk);
        fs_next = frame_start;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        servo_l = 8'd5;
        servo_r = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_pwm_l", int'(pwm_l), 0);
        check("rst_pwm_r", int'(pwm_r), 0);
        check("rst_frame_start", int'(frame_start), 0);

        // Frame 1: shadows still zero, so no pulse before the first strobe.
        rst_n = 1'b1;
        wait_fs(gap, l_hi, r_hi);
        check("f1_gap", gap, FRAME);
        check("f1_l_high", l_hi, 0);
        check("f1_r_high", r_hi, 0);

        // Frame 2: cmd 5 -> 15 us; left cmd changed mid-frame, right on the wrap edge.
        run_frame(60, 8'd40, FRAME - 1, 8'd255, -1, -1);
        check("f2_l_high", $countones(pw_l), 30);
        check("f2_l_first", first_one(pw_l), 1);
        check("f2_r_high", $countones(pw_r), 0);
        check("f2_fs_count", $countones(fs_v), 1);
        check("f2_fs_first", int'(fs_v[0]), 1);
        check("f2_fs_next", int'(fs_next), 1);

        // Frame 3: cmd 40 -> 50 us, cmd 255 -> 265 us.
        run_frame(-1, 8'd0, FRAME - 1, 8'd0, -1, -1);
        check("f3_l_high", $countones(pw_l), 100);
        check("f3_l_first", first_one(pw_l), 1);
        check("f3_l_last", last_one(pw_l), 100);
        check("f3_r_high", $countones(pw_r), 530);
        check("f3_r_first", first_one(pw_r), 1);
        check("f3_r_last", last_one(pw_r), 530);
        check("f3_fs_next", int'(fs_next), 1);

        // Frame 4: enable dropped mid-pulse, raised again while still inside the pulse window.
        run_frame(-1, 8'd0, -1, 8'd0, 6, 20);
        check("f4_l_high", $countones(pw_l), 86);
        check("f4_l_before_off", int'(pw_l[6]), 1);
        check("f4_l_after_off", int'(pw_l[7]), 0);
        check("f4_l_still_off", int'(pw_l[20]), 0);
        check("f4_l_resume", int'(pw_l[21]), 1);
        check("f4_l_last_high", int'(pw_l[100]), 1);
        check("f4_l_end", int'(pw_l[101]), 0);
        check("f4_r_high", $countones(pw_r), 0);
        check("f4_fs_next", int'(fs_next), 1);

        // Frame 5: asynchronous reset in the middle of a pulse.
        repeat (10) @(negedge clk);
        check("f5_l_mid_pulse", int'(pwm_l), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm_l", int'(pwm_l), 0);
        check("async_rst_pwm_r", int'(pwm_r), 0);
        check("async_rst_fs", int'(frame_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(gap, l_hi, r_hi);
        check("post_rst_gap", gap, FRAME);
        check("post_rst_l_high", l_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
